// File: rtl/ring_ctrl_pkg.sv
// Shared types and constants for the student-number ring sequencing controller.
package ring_ctrl_pkg;

  localparam int RING_LEN = 8;
  localparam int POS_W    = 3;

  typedef enum logic [1:0] {
    IDLE,
    STEP_HOLD,
    LOAD_HOLD
  } ctrl_state_e;

  // Head index after one shift; wraps from the last ring entry back to 0.
  function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
    return (p == POS_W'(RING_LEN - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus stability counter for one raw board switch.
// Outputs the accepted level and a one-cycle pulse when that level rises.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  // Any cycle where the synchronised input agrees with the accepted level
  // restarts the count, so a glitch shorter than DEBOUNCE_CYCLES is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      if (sync_2 == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q   <= '0;
        level_q <= sync_2;
        rise_q  <= sync_2;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/ring_step_ctrl.sv
// Sequencing controller for the rotating student-number ring: conditions the
// switches, issues shift/preload pulses (manual or auto) and tracks the head.
module ring_step_ctrl
  import ring_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PERIOD_W        = 24
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                STEP_IN,
  input  logic                RELOAD_IN,
  input  logic                AUTO_IN,
  input  logic [PERIOD_W-1:0] PERIOD,
  output logic                SHIFT_EN,
  output logic                LOAD,
  output logic [2:0]          POS,
  output logic                WRAP
);

  // SHIFT_EN and LOAD are registered single-cycle strobes with no back-pressure:
  // the ring acts on every edge that samples one high, and they are exclusive.

  logic step_lvl, step_rise;
  logic reload_lvl, reload_rise;
  logic auto_lvl, auto_rise_unused;

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk(CLK), .rst_n(RST), .raw(STEP_IN), .level(step_lvl), .rise(step_rise)
  );

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reload_db (
    .clk(CLK), .rst_n(RST), .raw(RELOAD_IN), .level(reload_lvl), .rise(reload_rise)
  );

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_auto_db (
    .clk(CLK), .rst_n(RST), .raw(AUTO_IN), .level(auto_lvl), .rise(auto_rise_unused)
  );

  ctrl_state_e         state_q, state_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                shift_q, shift_d;
  logic                load_q, load_d;
  logic                wrap_q, wrap_d;
  logic                period_on;
  logic                tick;

  assign period_on = (PERIOD != '0);
  // >= rather than == so a PERIOD lowered below the running count still ticks.
  assign tick      = period_on && (timer_q >= (PERIOD - PERIOD_W'(1)));

  always_comb begin
    state_d = state_q;
    timer_d = '0;
    shift_d = 1'b0;
    load_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (reload_rise) begin
          load_d  = 1'b1;
          state_d = LOAD_HOLD;
        end else if (!auto_lvl) begin
          if (step_rise) begin
            shift_d = 1'b1;
            state_d = STEP_HOLD;
          end
        end else if (period_on) begin
          if (tick) shift_d = 1'b1;
          else      timer_d = timer_q + 1'b1;
        end
      end
      STEP_HOLD: begin
        if (reload_rise) begin
          load_d  = 1'b1;
          state_d = LOAD_HOLD;
        end else if (!step_lvl) begin
          state_d = IDLE;
        end
      end
      LOAD_HOLD: begin
        if (!reload_lvl) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // POS follows the ring itself: it moves on the edge that samples a strobe.
    pos_d = pos_q;
    if (load_q)       pos_d = '0;
    else if (shift_q) pos_d = pos_inc(pos_q);
    wrap_d = shift_d && (pos_d == POS_W'(RING_LEN - 1));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      timer_q <= '0;
      pos_q   <= '0;
      shift_q <= 1'b0;
      load_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pos_q   <= pos_d;
      shift_q <= shift_d;
      load_q  <= load_d;
      wrap_q  <= wrap_d;
    end
  end

  assign SHIFT_EN = shift_q;
  assign LOAD     = load_q;
  assign POS      = pos_q;
  assign WRAP     = wrap_q;

endmodule

// File: tb/tb_ring_step_ctrl.sv
// Directed self-checking bench for ring_step_ctrl with a 4-cycle debounce.
module tb_ring_step_ctrl;

  localparam int DB = 4;
  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          step_in = 1'b0;
  logic          reload_in = 1'b0;
  logic          auto_in = 1'b0;
  logic [PW-1:0] period = '0;
  logic          shift_en;
  logic          load;
  logic [2:0]    pos;
  logic          wrap;

  int n_pass = 0;
  int n_total = 0;
  int shift_cnt = 0;
  int load_cnt = 0;
  int wrap_cnt = 0;
  int both_cnt = 0;
  int wrap_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  ring_step_ctrl #(.DEBOUNCE_CYCLES(DB), .PERIOD_W(PW)) dut (
    .CLK(clk), .RST(rst_n), .STEP_IN(step_in), .RELOAD_IN(reload_in),
    .AUTO_IN(auto_in), .PERIOD(period), .SHIFT_EN(shift_en), .LOAD(load),
    .POS(pos), .WRAP(wrap)
  );

  always @(posedge clk) cyc++;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (shift_en === 1'b1) shift_cnt++;
    if (load === 1'b1) load_cnt++;
    if (wrap === 1'b1) wrap_cnt++;
    if (shift_en === 1'b1 && load === 1'b1) both_cnt++;
    if (wrap !== (shift_en && (pos == 3'd7))) wrap_bad++;
  end

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_shift(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      cyc_wait(1);
      if (shift_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    step_in = 1'b0;
    reload_in = 1'b0;
    auto_in = 1'b0;
    period = '0;
    rst_n = 1'b0;
    cyc_wait(3);
    rst_n = 1'b1;
    cyc_wait(2);
  endtask

  // Clean press: shift appears 7 samples in, release settles well within 12.
  task automatic press_step(input int hold);
    step_in = 1'b1;
    cyc_wait(hold);
    step_in = 1'b0;
    cyc_wait(12);
  endtask

  task automatic test_reset();
    bit found;
    int base;
    do_reset();
    n_total++; if (pos !== 3'd0) $display("FAIL reset_pos: got %0d expected 0", pos); else n_pass++;
    n_total++; if (shift_en !== 1'b0) $display("FAIL reset_shift: got %b expected 0", shift_en); else n_pass++;
    n_total++; if (load !== 1'b0) $display("FAIL reset_load: got %b expected 0", load); else n_pass++;
    n_total++; if (wrap !== 1'b0) $display("FAIL reset_wrap: got %b expected 0", wrap); else n_pass++;
    // Run auto at PERIOD=1 until POS=5 with a shift in flight, then reset.
    period = 1;
    auto_in = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc_wait(1);
      if (pos == 3'd5 && shift_en === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    n_total++; if (!found) $display("FAIL midrun_reach: got timeout expected POS=5 with SHIFT_EN"); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (pos !== 3'd0) $display("FAIL midrun_pos: got %0d expected 0", pos); else n_pass++;
    n_total++; if (shift_en !== 1'b0) $display("FAIL midrun_shift: got %b expected 0", shift_en); else n_pass++;
    n_total++; if (load !== 1'b0) $display("FAIL midrun_load: got %b expected 0", load); else n_pass++;
    n_total++; if (wrap !== 1'b0) $display("FAIL midrun_wrap: got %b expected 0", wrap); else n_pass++;
    auto_in = 1'b0;
    period = '0;
    step_in = 1'b1;
    cyc_wait(3);
    base = shift_cnt;
    rst_n = 1'b1;
    cyc_wait(20);
    n_total++; if (shift_cnt - base != 1) $display("FAIL held_step_count: got %0d expected 1", shift_cnt - base); else n_pass++;
    n_total++; if (pos !== 3'd1) $display("FAIL held_step_pos: got %0d expected 1", pos); else n_pass++;
    step_in = 1'b0;
    cyc_wait(12);
  endtask

  task automatic test_glitch();
    int base;
    base = shift_cnt;
    for (int i = 0; i < 6; i++) begin
      step_in = 1'b1;
      cyc_wait(2);
      step_in = 1'b0;
      cyc_wait(2);
    end
    cyc_wait(10);
    n_total++; if (shift_cnt - base != 0) $display("FAIL glitch_count: got %0d expected 0", shift_cnt - base); else n_pass++;
    n_total++; if (pos !== 3'd1) $display("FAIL glitch_pos: got %0d expected 1", pos); else n_pass++;
  endtask

  task automatic test_latency();
    int base;
    int first;
    base = shift_cnt;
    first = 0;
    step_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc_wait(1);
      if (shift_en === 1'b1 && first == 0) first = k;
    end
    n_total++; if (first != 7) $display("FAIL press_latency: got %0d expected 7", first); else n_pass++;
    cyc_wait(40);
    n_total++; if (shift_cnt - base != 1) $display("FAIL long_hold_count: got %0d expected 1", shift_cnt - base); else n_pass++;
    step_in = 1'b0;
    cyc_wait(12);
    n_total++; if (pos !== 3'd2) $display("FAIL long_hold_pos: got %0d expected 2", pos); else n_pass++;
  endtask

  task automatic test_manual_steps();
    int bs;
    int bw;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      bs = shift_cnt;
      bw = wrap_cnt;
      press_step(10);
      n_total++; if (shift_cnt - bs != 1) $display("FAIL step%0d_count: got %0d expected 1", i, shift_cnt - bs); else n_pass++;
      n_total++; if (pos !== 3'(i % 8)) $display("FAIL step%0d_pos: got %0d expected %0d", i, pos, i % 8); else n_pass++;
      n_total++; if (wrap_cnt - bw != ((i == 8) ? 1 : 0))
        $display("FAIL step%0d_wrap: got %0d expected %0d", i, wrap_cnt - bw, (i == 8) ? 1 : 0);
      else n_pass++;
    end
  endtask

  task automatic test_reload_priority();
    int bs;
    int bl;
    do_reset();
    repeat (3) press_step(10);
    n_total++; if (pos !== 3'd3) $display("FAIL prio_setup_pos: got %0d expected 3", pos); else n_pass++;
    bs = shift_cnt;
    bl = load_cnt;
    step_in = 1'b1;
    reload_in = 1'b1;
    cyc_wait(12);
    n_total++; if (load_cnt - bl != 1) $display("FAIL prio_load: got %0d expected 1", load_cnt - bl); else n_pass++;
    n_total++; if (shift_cnt - bs != 0) $display("FAIL prio_shift: got %0d expected 0", shift_cnt - bs); else n_pass++;
    n_total++; if (pos !== 3'd0) $display("FAIL prio_pos: got %0d expected 0", pos); else n_pass++;
    step_in = 1'b0;
    cyc_wait(12);
    press_step(10);
    n_total++; if (shift_cnt - bs != 0) $display("FAIL hold_step_ignored: got %0d expected 0", shift_cnt - bs); else n_pass++;
    n_total++; if (load_cnt - bl != 1) $display("FAIL hold_single_load: got %0d expected 1", load_cnt - bl); else n_pass++;
    reload_in = 1'b0;
    cyc_wait(12);
    press_step(10);
    n_total++; if (shift_cnt - bs != 1) $display("FAIL post_reload_step: got %0d expected 1", shift_cnt - bs); else n_pass++;
    n_total++; if (pos !== 3'd1) $display("FAIL post_reload_pos: got %0d expected 1", pos); else n_pass++;
  endtask

  task automatic test_auto();
    bit ok;
    int prev;
    int bw;
    int base;
    do_reset();
    period = 10;
    auto_in = 1'b1;
    wait_shift(40, ok);
    n_total++; if (!ok) $display("FAIL auto_first: got timeout expected a pulse"); else n_pass++;
    prev = cyc;
    bw = wrap_cnt;
    for (int j = 1; j <= 16; j++) begin
      wait_shift(15, ok);
      n_total++; if (!ok || cyc - prev != 10)
        $display("FAIL auto_spacing%0d: got %0d expected 10 (seen=%0d)", j, cyc - prev, ok);
      else n_pass++;
      prev = cyc;
    end
    n_total++; if (wrap_cnt - bw != 2) $display("FAIL auto_wraps: got %0d expected 2", wrap_cnt - bw); else n_pass++;
    cyc_wait(1);
    n_total++; if (pos !== 3'd1) $display("FAIL auto_pos: got %0d expected 1", pos); else n_pass++;
    period = '0;
    base = shift_cnt;
    cyc_wait(40);
    n_total++; if (shift_cnt - base != 0) $display("FAIL period0_count: got %0d expected 0", shift_cnt - base); else n_pass++;
    period = 1;
    cyc_wait(2);
    base = shift_cnt;
    cyc_wait(20);
    n_total++; if (shift_cnt - base != 20) $display("FAIL period1_count: got %0d expected 20", shift_cnt - base); else n_pass++;
    n_total++; if (shift_en !== 1'b1) $display("FAIL period1_level: got %b expected 1", shift_en); else n_pass++;
  endtask

  task automatic test_auto_reload_and_mode();
    bit ok;
    int e;
    int bl;
    int bs;
    int base;
    period = 10;
    cyc_wait(2);
    wait_shift(20, ok);
    n_total++; if (!ok) $display("FAIL reauto_sync: got timeout expected a pulse"); else n_pass++;
    // Pulse at edge e; RELOAD first sampled at e+1 reaches the FSM with timer=6,
    // LOAD_HOLD is left at e+17, so the next shift is registered at e+27.
    e = cyc;
    bl = load_cnt;
    bs = shift_cnt;
    reload_in = 1'b1;
    cyc_wait(10);
    reload_in = 1'b0;
    wait_shift(40, ok);
    n_total++; if (!ok || cyc != e + 27)
      $display("FAIL reload_restart: got edge %0d expected %0d (seen=%0d)", cyc - e, 27, ok);
    else n_pass++;
    n_total++; if (load_cnt - bl != 1) $display("FAIL auto_reload_load: got %0d expected 1", load_cnt - bl); else n_pass++;
    n_total++; if (shift_cnt - bs != 1) $display("FAIL auto_reload_shifts: got %0d expected 1", shift_cnt - bs); else n_pass++;
    n_total++; if (pos !== 3'd0) $display("FAIL auto_reload_pos: got %0d expected 0", pos); else n_pass++;
    auto_in = 1'b0;
    base = shift_cnt;
    cyc_wait(40);
    n_total++; if (shift_cnt - base != 0) $display("FAIL mode_drop_count: got %0d expected 0", shift_cnt - base); else n_pass++;
    press_step(10);
    n_total++; if (shift_cnt - base != 1) $display("FAIL manual_again: got %0d expected 1", shift_cnt - base); else n_pass++;
    n_total++; if (pos !== 3'd2) $display("FAIL manual_again_pos: got %0d expected 2", pos); else n_pass++;
  endtask

  task automatic test_exclusive();
    n_total++; if (both_cnt != 0) $display("FAIL shift_load_overlap: got %0d expected 0", both_cnt); else n_pass++;
    n_total++; if (wrap_bad != 0) $display("FAIL wrap_consistency: got %0d expected 0", wrap_bad); else n_pass++;
  endtask

  initial begin
    #1;
    test_reset();
    test_glitch();
    test_latency();
    test_manual_steps();
    test_reload_priority();
    test_auto();
    test_auto_reload_and_mode();
    test_exclusive();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ring_step_ctrl.md
# ring_step_ctrl

Sequencing controller for the 8-entry, 8-bit rotating register ring that holds the student number. It replaces direct switch clocking: it synchronises and debounces the raw board switches. It then issues single-cycle shift and preload enables to the ring on the system clock, either one shift per button press or periodic auto-rotation. It also tracks the ring head position for the top level.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles needed to accept a switch level change.
- PERIOD_W, 24: width of the auto-rotate period input.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- STEP_IN  in  1  raw step switch, asynchronous to CLK.
- RELOAD_IN  in  1  raw reload switch, asynchronous to CLK.
- AUTO_IN  in  1  raw mode switch: 1 = auto-rotate, 0 = manual.
- PERIOD  in  PERIOD_W  auto-rotate period in CLK cycles. Quasi-static. 0 disables auto shifts.
- SHIFT_EN  out  1  one-cycle pulse. The ring shifts on the edge that samples it high.
- LOAD  out  1  one-cycle pulse. The ring loads its preload values on the edge that samples it high.
- POS  out  3  index of the ring entry currently on the output, 0..7.
- WRAP  out  1  high together with SHIFT_EN when POS is 7, i.e. the shift completes a full rotation.

## Operation
- **Input conditioning.** Each raw input passes through a 2-flop synchroniser and then a debouncer.
  - The debounced level changes only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any glitch restarts the count.
- **FSM.** Three states, IDLE, STEP_HOLD and LOAD_HOLD. Reset state is IDLE.
  - IDLE, debounced RELOAD rises: LOAD = 1 for one cycle, POS <= 0, auto timer cleared, go to LOAD_HOLD.
  - IDLE, manual mode, debounced STEP rises: SHIFT_EN = 1 for one cycle, go to STEP_HOLD.
  - IDLE, auto mode, timer tick: SHIFT_EN = 1 for one cycle, stay in IDLE.
  - STEP_HOLD: no further manual shifts. Go to IDLE when debounced STEP is 0. A debounced RELOAD rise still takes effect, with LOAD_HOLD as the next state.
  - LOAD_HOLD: no shifts and no further loads. Go to IDLE when debounced RELOAD is 0.
- **Priority.** RELOAD beats STEP and beats the auto tick. A step or tick coincident with a reload is discarded, not deferred.
- **Auto timer.** Free-runs in IDLE while in auto mode with PERIOD ≥ 1.
  - Counts 0..PERIOD-1 and ticks when it reaches PERIOD-1, then wraps to 0.
  - PERIOD = 1 gives a shift every cycle.
  - Held at 0 in manual mode, in either HOLD state, and when PERIOD = 0.
  - STEP_IN is ignored in auto mode.
  - A mode change takes effect at the debounced AUTO edge. Leaving auto clears the timer.
- **Position tracking.** POS increments modulo 8 on the edge that samples SHIFT_EN high, so 7 goes to 0.
  - WRAP is combinationally equal to SHIFT_EN when POS is 7. It is registered, with the same timing as SHIFT_EN.
- SHIFT_EN and LOAD are never high in the same cycle.

## Timing
- **Reset.** Reset is asynchronous and active-low. It forces the following, and release is then synchronous to CLK:
  - SHIFT_EN = 0, LOAD = 0, WRAP = 0, POS = 0.
  - State = IDLE.
  - Synchronisers, debounce counters, debounced levels and the auto timer all 0.
- **Switch held across reset release.** The debounced level starts at 0, so it is treated as a fresh press and yields exactly one action.
- **Reset mid-pulse.** Aborts the pulse; no partial action is retained.
- **Latency.** A clean raw rise first sampled at edge n gives SHIFT_EN (manual) or LOAD high in the cycle after edge n + DEBOUNCE_CYCLES + 2, for exactly one cycle.
- **Auto spacing.** With a constant PERIOD = P ≥ 1, consecutive auto SHIFT_EN pulses are exactly P cycles apart.
- **Per-press count.** Exactly one SHIFT_EN per accepted press, regardless of hold length.

## Structure
- **Package ring_ctrl_pkg** holds:
  - the state enum {IDLE, STEP_HOLD, LOAD_HOLD};
  - RING_LEN = 8;
  - POS_W = 3.
- **Sub-module sw_debounce** (synchroniser plus debounce counter, parameter DEBOUNCE_CYCLES).
  - Instantiated three times, for STEP, RELOAD and AUTO.
  - Outputs the debounced level and a one-cycle rise pulse.
- **Top level.** ring_step_ctrl holds the FSM, the auto timer and the POS counter.
  - The top-level design instantiates it alongside the ring and drives the ring enables from SHIFT_EN and LOAD.

## Test plan
All scenarios run with DEBOUNCE_CYCLES = 4.
- **Reset values.** Assert RST = 0 mid-run with POS = 5 and SHIFT_EN high → all outputs 0 immediately. After release, hold STEP_IN high → exactly one SHIFT_EN.
- **Manual stepping and bounce rejection.**
  - Toggle STEP_IN with 2-cycle glitches → no SHIFT_EN.
  - Clean press held 50 cycles → one SHIFT_EN, 7 cycles after the first high sample.
  - 9 presses → POS sequence 1..7, 0, 1, with WRAP on the 8th press.
- **Reload priority.** STEP_IN and RELOAD_IN rise on the same cycle with POS = 3 → LOAD pulse, no SHIFT_EN, POS = 0. STEP_IN ignored until RELOAD_IN releases.
- **Auto rotate.**
  - AUTO_IN = 1, PERIOD = 10 → SHIFT_EN every 10 cycles; 16 pulses give two WRAP pulses.
  - PERIOD = 0 → no pulses.
  - PERIOD = 1 → SHIFT_EN every cycle.
- **Mode switch and reload in auto.**
  - Reload during auto at timer = 6 → timer restarts; the next SHIFT_EN comes PERIOD cycles after leaving LOAD_HOLD.
  - Dropping AUTO_IN → pulses stop after the debounce delay, and STEP_IN is honoured again.
